// File: rtl/register_scoreboard_pkg.sv
// Shared constants for the register scoreboard: default sizes,
// the life reload value and the hard-wired zero register index.
package register_scoreboard_pkg;

    localparam int DEF_NB_REGS      = 32;
    localparam int DEF_NB_STALL_CNT = 16;
    localparam int REG_IDX_W        = 5;

    typedef logic [1:0] life_t;

    // A recorded write stays visible through EX, MEM and WB.
    localparam life_t LIFE_RELOAD = 2'd3;

    localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/register_scoreboard_entry.sv
// One scoreboard slot: load-pending flag plus 2-bit life counter.
// Ports: i_clk, i_reset (async, high), i_halt, i_record, i_record_ld,
//        o_ld (load pending), o_life (cycles left in flight).
module scoreboard_entry
    import register_scoreboard_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_halt,
    input  logic       i_record,
    input  logic       i_record_ld,
    output logic       o_ld,
    output logic [1:0] o_life
);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_ld   <= 1'b0;
            o_life <= '0;
        end else if (!i_halt) begin
            if (i_record) begin
                o_ld   <= i_record_ld;
                o_life <= LIFE_RELOAD;
            end else begin
                // A load only blocks the instruction right behind it;
                // later consumers are served by forwarding.
                o_ld <= 1'b0;
                if (o_life != '0) begin
                    o_life <= o_life - 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/register_scoreboard.sv
// Register scoreboard: tracks in-flight writes and raises a load-use stall.
// Ports: i_clk, i_reset, i_halt, issue bundle (i_issue_*), i_flush,
//        ID sources (i_id_rs/rt, i_id_use_rs/rt),
//        o_stall, o_busy_mask, o_stall_cnt.
module register_scoreboard
    import register_scoreboard_pkg::*;
#(
    parameter int NB_REGS      = DEF_NB_REGS,
    parameter int NB_STALL_CNT = DEF_NB_STALL_CNT
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_halt,
    input  logic                    i_issue_valid,
    input  logic                    i_issue_wb,
    input  logic                    i_issue_mem_read,
    input  logic [4:0]              i_issue_rd,
    input  logic                    i_flush,
    input  logic [4:0]              i_id_rs,
    input  logic [4:0]              i_id_rt,
    input  logic                    i_id_use_rs,
    input  logic                    i_id_use_rt,
    output logic                    o_stall,
    output logic [NB_REGS-1:0]      o_busy_mask,
    output logic [NB_STALL_CNT-1:0] o_stall_cnt
);

    logic [NB_REGS-1:0] ld;
    logic               record;
    logic               rs_ld;
    logic               rt_ld;

    // A stalled cycle turns the issue into a bubble, so nothing is recorded.
    assign record = i_issue_valid && i_issue_wb && !i_flush &&
                    !o_stall && !i_halt && (i_issue_rd != REG_ZERO);

    assign ld[0]          = 1'b0;
    assign o_busy_mask[0] = 1'b0;

    for (genvar r = 1; r < NB_REGS; r++) begin : g_entry
        logic [1:0] life;

        scoreboard_entry u_entry (
            .i_clk       (i_clk),
            .i_reset     (i_reset),
            .i_halt      (i_halt),
            .i_record    (record && (i_issue_rd == REG_IDX_W'(r))),
            .i_record_ld (i_issue_mem_read),
            .o_ld        (ld[r]),
            .o_life      (life)
        );

        assign o_busy_mask[r] = (life != '0);
    end

    always_comb begin
        rs_ld = 1'b0;
        rt_ld = 1'b0;
        for (int r = 0; r < NB_REGS; r++) begin
            if (i_id_rs == REG_IDX_W'(r)) rs_ld = ld[r];
            if (i_id_rt == REG_IDX_W'(r)) rt_ld = ld[r];
        end
        o_stall = (i_id_use_rs && (i_id_rs != REG_ZERO) && rs_ld) ||
                  (i_id_use_rt && (i_id_rt != REG_ZERO) && rt_ld);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_stall_cnt <= '0;
        end else if (!i_halt && o_stall && (o_stall_cnt != '1)) begin
            o_stall_cnt <= o_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed bench for register_scoreboard with hand-computed expectations.
// Stall counter is narrowed to 8 bits so saturation is reachable quickly.
module tb_register_scoreboard;

    localparam int NR = 32;
    localparam int NC = 8;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_halt;
    logic          i_issue_valid;
    logic          i_issue_wb;
    logic          i_issue_mem_read;
    logic [4:0]    i_issue_rd;
    logic          i_flush;
    logic [4:0]    i_id_rs;
    logic [4:0]    i_id_rt;
    logic          i_id_use_rs;
    logic          i_id_use_rt;
    logic          o_stall;
    logic [NR-1:0] o_busy_mask;
    logic [NC-1:0] o_stall_cnt;

    int total = 0;
    int bad   = 0;

    register_scoreboard #(
        .NB_REGS      (NR),
        .NB_STALL_CNT (NC)
    ) dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_halt           (i_halt),
        .i_issue_valid    (i_issue_valid),
        .i_issue_wb       (i_issue_wb),
        .i_issue_mem_read (i_issue_mem_read),
        .i_issue_rd       (i_issue_rd),
        .i_flush          (i_flush),
        .i_id_rs          (i_id_rs),
        .i_id_rt          (i_id_rt),
        .i_id_use_rs      (i_id_use_rs),
        .i_id_use_rt      (i_id_use_rt),
        .o_stall          (o_stall),
        .o_busy_mask      (o_busy_mask),
        .o_stall_cnt      (o_stall_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #2;
    endtask

    task automatic set_issue(input logic v, input logic wb, input logic mr,
                             input logic [4:0] rd, input logic fl);
        i_issue_valid    = v;
        i_issue_wb       = wb;
        i_issue_mem_read = mr;
        i_issue_rd       = rd;
        i_flush          = fl;
    endtask

    task automatic set_id(input logic urs, input logic [4:0] rs,
                          input logic urt, input logic [4:0] rt);
        i_id_use_rs = urs;
        i_id_rs     = rs;
        i_id_use_rt = urt;
        i_id_rt     = rt;
    endtask

    task automatic idle();
        set_issue(0, 0, 0, 0, 0);
        set_id(0, 0, 0, 0);
    endtask

    initial begin
        i_reset = 1'b1;
        i_halt  = 1'b0;
        idle();
        cyc();
        cyc();
        // reset state, with a consumer of r5 presented
        set_id(1, 5, 1, 5);
        #1;
        chk("rst_stall", 32'(o_stall), 0);
        chk("rst_busy", o_busy_mask, 0);
        chk("rst_cnt", 32'(o_stall_cnt), 0);
        i_reset = 1'b0;
        idle();
        cyc();

        // lw r5, then consumer of rs=5
        set_issue(1, 1, 1, 5, 0);
        #1;
        chk("lw5_issue_stall", 32'(o_stall), 0);
        cyc();
        set_issue(1, 1, 0, 10, 0);
        set_id(1, 5, 0, 0);
        #1;
        chk("lw5_stall", 32'(o_stall), 1);
        chk("lw5_busy1", o_busy_mask, 32'h20);
        chk("lw5_cnt0", 32'(o_stall_cnt), 0);
        cyc();
        #1;
        chk("lw5_unstall", 32'(o_stall), 0);
        chk("lw5_busy2", o_busy_mask, 32'h20);
        chk("lw5_cnt1", 32'(o_stall_cnt), 1);
        cyc();
        idle();
        #1;
        chk("lw5_busy3", o_busy_mask, 32'h420);
        cyc();
        #1;
        chk("lw5_free", o_busy_mask, 32'h400);
        cyc();
        cyc();
        #1;
        chk("r10_free", o_busy_mask, 0);

        // add r7, consumer of rt=7: forwarded, no stall
        set_issue(1, 1, 0, 7, 0);
        cyc();
        set_issue(1, 0, 0, 0, 0);
        set_id(0, 0, 1, 7);
        #1;
        chk("add7_stall", 32'(o_stall), 0);
        chk("add7_busy1", o_busy_mask, 32'h80);
        cyc();
        idle();
        #1;
        chk("add7_busy2", o_busy_mask, 32'h80);
        cyc();
        #1;
        chk("add7_busy3", o_busy_mask, 32'h80);
        cyc();
        #1;
        chk("add7_free", o_busy_mask, 0);
        chk("add7_cnt", 32'(o_stall_cnt), 1);

        // lw r0: never recorded
        set_issue(1, 1, 1, 0, 0);
        cyc();
        set_issue(1, 0, 0, 0, 0);
        set_id(1, 0, 0, 0);
        #1;
        chk("lw0_stall", 32'(o_stall), 0);
        chk("lw0_busy", o_busy_mask, 0);
        cyc();

        // flushed lw r9: not recorded
        set_issue(1, 1, 1, 9, 1);
        set_id(0, 0, 0, 0);
        cyc();
        set_issue(1, 0, 0, 0, 0);
        set_id(1, 9, 0, 0);
        #1;
        chk("flush9_stall", 32'(o_stall), 0);
        chk("flush9_busy", o_busy_mask, 0);
        cyc();

        // lw r3, then halt for 4 cycles with consumer of r3 in ID
        set_issue(1, 1, 1, 3, 0);
        set_id(0, 0, 0, 0);
        cyc();
        set_issue(1, 1, 0, 11, 0);
        set_id(1, 3, 0, 0);
        i_halt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("halt_stall", 32'(o_stall), 1);
            chk("halt_cnt", 32'(o_stall_cnt), 1);
            chk("halt_busy", o_busy_mask, 32'h8);
            cyc();
        end
        i_halt = 1'b0;
        #1;
        chk("rel_stall", 32'(o_stall), 1);
        cyc();
        #1;
        chk("rel_unstall", 32'(o_stall), 0);
        chk("rel_cnt", 32'(o_stall_cnt), 2);
        chk("rel_busy", o_busy_mask, 32'h8);
        cyc();
        idle();
        #1;
        chk("rel_busy2", o_busy_mask, 32'h808);
        cyc();
        cyc();
        cyc();
        #1;
        chk("rel_free", o_busy_mask, 0);

        // alternating lw r4 / consumer: one stall per pair
        for (int k = 0; k < 252; k++) begin
            set_issue(1, 1, 1, 4, 0);
            set_id(0, 0, 0, 0);
            cyc();
            set_issue(1, 0, 0, 0, 0);
            set_id(1, 4, 0, 0);
            cyc();
        end
        #1;
        chk("sat_254", 32'(o_stall_cnt), 254);
        for (int k = 0; k < 8; k++) begin
            set_issue(1, 1, 1, 4, 0);
            set_id(0, 0, 0, 0);
            cyc();
            set_issue(1, 0, 0, 0, 0);
            set_id(1, 4, 0, 0);
            cyc();
        end
        #1;
        chk("sat_255", 32'(o_stall_cnt), 255);

        // async reset in the middle of a stall cycle
        set_issue(1, 1, 1, 4, 0);
        set_id(0, 0, 0, 0);
        cyc();
        set_issue(1, 0, 0, 0, 0);
        set_id(1, 4, 0, 0);
        #1;
        chk("pre_rst_stall", 32'(o_stall), 1);
        chk("pre_rst_busy", o_busy_mask, 32'h10);
        i_reset = 1'b1;
        #1;
        chk("arst_stall", 32'(o_stall), 0);
        chk("arst_busy", o_busy_mask, 0);
        chk("arst_cnt", 32'(o_stall_cnt), 0);
        #1;
        i_reset = 1'b0;
        cyc();
        #1;
        chk("post_rst_cnt", 32'(o_stall_cnt), 0);
        chk("post_rst_busy", o_busy_mask, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
